bcm_acquisition_accumulator: RTL

Multi-pass, multi-channel ADC acquisition accumulator for the bunch current monitor, in the ADC clock domain only. Captures a programmable window after a delayed trigger, sums or peak-holds it over a programmable number of passes into block RAM, and offers a registered readout port. It is the parametrised successor to the current BCM acquisition. It adds a trigger delay, per-pass retriggering, abort, overrun detection and a peak-hold mode. All control and status clock crossing is done outside this block.

---
 rtl/bcm_acquisition_accumulator.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/bcm_acquisition_accumulator.sv
// Multi-pass, multi-lane ADC window accumulator (sum, or peak-hold when
// BCM_PEAK_HOLD_EN is defined) backed by block RAM, with a registered readout port.

module bcm_acc_lane #(
  parameter int SW  = 16,
  parameter int AW  = 14,
  parameter int ACC = 22
) (
  input  logic [SW-1:0]  i_field,
  input  logic [ACC-1:0] i_old,
  input  logic           i_first,
  input  logic           i_peak,
  output logic [ACC-1:0] o_new
);
  logic [AW-1:0]  w_adc;
  logic [ACC-1:0] w_samp;
  logic           w_unused;

  // ADC value is left-justified in the field; the low pad bits are dropped
  assign w_adc  = i_field[SW-1 -: AW];
  assign w_samp = {{(ACC-AW){w_adc[AW-1]}}, w_adc};

`ifdef BCM_PEAK_HOLD_EN
  logic w_keep;
  assign w_keep = $signed(i_old) >= $signed(w_samp);
  always_comb begin
    if (i_first)     o_new = w_samp;
    else if (i_peak) o_new = w_keep ? i_old : w_samp;
    else             o_new = i_old + w_samp;
  end
  assign w_unused = ^i_field;
`else
  assign o_new    = i_first ? w_samp : i_old + w_samp;
  assign w_unused = ^{i_field, i_peak};
`endif
endmodule

module bcm_acquisition_accumulator #(
  parameter int CHANNEL_COUNT     = 2,
  parameter int SAMPLES_PER_CLOCK = 4,
  parameter int SAMPLE_WIDTH      = 16,
  parameter int ADC_WIDTH         = 14,
  parameter int SAMPLE_CAPACITY   = 1024,
  parameter int MAX_PASSES        = 256,
  parameter int DELAY_WIDTH       = 16,
  localparam int ADDR_W = $clog2(SAMPLE_CAPACITY / SAMPLES_PER_CLOCK),
  localparam int PASS_W = $clog2(MAX_PASSES) + 1,
  localparam int ACC_W  = ADC_WIDTH + $clog2(MAX_PASSES),
  localparam int CH_W   = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1,
  localparam int SMP_W  = (SAMPLES_PER_CLOCK > 1) ? $clog2(SAMPLES_PER_CLOCK) : 1,
  localparam int LANES  = CHANNEL_COUNT * SAMPLES_PER_CLOCK
) (
  input  logic                          adcClk,
  input  logic                          adcResetN,
  input  logic [LANES*SAMPLE_WIDTH-1:0] axiData,
  input  logic                          arm,
  input  logic                          abort,
  input  logic                          trigger,
  input  logic [ADDR_W-1:0]             cfgLength,
  input  logic [PASS_W-1:0]             cfgPasses,
  input  logic [DELAY_WIDTH-1:0]        cfgDelay,
  input  logic                          cfgRetrigger,
  input  logic                          cfgMode,
  output logic                          armed,
  output logic                          busy,
  output logic                          done,
  output logic                          overrun,
  output logic [PASS_W-1:0]             passCount,
  input  logic                          rdStrobe,
  input  logic [ADDR_W-1:0]             rdAddr,
  input  logic [CH_W-1:0]               rdChannel,
  input  logic [SMP_W-1:0]              rdSample,
  output logic                          rdValid,
  output logic [31:0]                   rdData
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int SHIFT  = SAMPLE_WIDTH - ADC_WIDTH;
  localparam int LANE_W = CH_W + ((SAMPLES_PER_CLOCK > 1) ? SMP_W : 0);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_DELAY, S_CAPTURE, S_GAP, S_FLUSH} state_t;

  state_t                                  r_state;
  logic [ADDR_W-1:0]                       r_len, r_addr;
  logic [PASS_W-1:0]                       r_passes;
  logic [DELAY_WIDTH-1:0]                  r_delayCfg, r_delay;
  logic                                    r_retrig, r_mode;
  logic [1:0]                              r_flush;

  logic [2:0]                              r_cVld, r_first;
  logic [2:0][ADDR_W-1:0]                  r_cAddr;
  logic [2:0][LANES-1:0][SAMPLE_WIDTH-1:0] r_samp;
  logic [LANES-1:0][ACC_W-1:0]             r_q, r_old, w_new;
  logic [LANES-1:0][ACC_W-1:0]             r_mem [DEPTH];

  logic [2:0]                              r_rdVld;
  logic [ADDR_W-1:0]                       r_rdA;
  logic [1:0][LANE_W-1:0]                  r_rdLane;
  logic [ACC_W-1:0]                        r_rdAcc;

  logic [LANES-1:0][SAMPLE_WIDTH-1:0]      w_axi;
  logic [ADDR_W-1:0]                       w_lenCfg, w_ramRdAddr;
  logic [LANE_W-1:0]                       w_rdLane;
  logic [31:0]                             w_rdExt;
  logic                                    w_abortNow, w_we;

  assign w_axi       = axiData;
  assign w_lenCfg    = (cfgLength < ADDR_W'(3)) ? ADDR_W'(3) : cfgLength;
  assign w_abortNow  = abort && (r_state != S_IDLE);
  assign w_we        = r_cVld[2] && adcResetN && !w_abortNow;
  // Readout only runs in IDLE, so it never collides with a capture read
  assign w_ramRdAddr = r_rdVld[0] ? r_rdA : r_cAddr[0];
  assign w_rdExt     = {{(32-ACC_W){r_rdAcc[ACC_W-1]}}, r_rdAcc} << SHIFT;

  generate
    if (SAMPLES_PER_CLOCK > 1) begin : g_sel
      assign w_rdLane = {rdChannel, rdSample};
    end else begin : g_sel1
      logic w_unused_smp;
      assign w_rdLane     = rdChannel;
      assign w_unused_smp = ^rdSample;
    end
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      bcm_acc_lane #(.SW(SAMPLE_WIDTH), .AW(ADC_WIDTH), .ACC(ACC_W)) u_lane (
        .i_field (r_samp[2][l]),
        .i_old   (r_old[l]),
        .i_first (r_first[2]),
        .i_peak  (r_mode),
        .o_new   (w_new[l])
      );
    end
  endgenerate

  always_ff @(posedge adcClk) begin
    if (!adcResetN) begin
      r_state <= S_IDLE;  armed <= 1'b0;  busy <= 1'b0;  done <= 1'b0;
      overrun <= 1'b0;    passCount <= '0;
      r_len <= '0;  r_passes <= '0;  r_delayCfg <= '0;  r_retrig <= 1'b0;  r_mode <= 1'b0;
      r_delay <= '0;  r_addr <= '0;  r_flush <= '0;
      r_cVld <= '0;  r_cAddr <= '0;  r_first <= '0;  r_samp <= '0;  r_old <= '0;
    end else begin
      done    <= 1'b0;
      r_cVld  <= {r_cVld[1:0], 1'b0};
      r_cAddr <= {r_cAddr[1:0], r_addr};
      r_first <= {r_first[1:0], passCount == '0};
      r_samp  <= {r_samp[1:0], w_axi};
      r_old   <= r_q;
      if (w_abortNow) begin
        r_state <= S_IDLE;  armed <= 1'b0;  busy <= 1'b0;
        r_cVld  <= '0;      r_addr <= '0;
      end else begin
        case (r_state)
          S_IDLE: if (arm && !abort) begin
            r_len <= w_lenCfg;  r_passes <= cfgPasses;  r_delayCfg <= cfgDelay;
            r_retrig <= cfgRetrigger;  r_mode <= cfgMode;
            passCount <= '0;  overrun <= 1'b0;  r_addr <= '0;
            r_state <= S_ARMED;  armed <= 1'b1;  busy <= 1'b1;
          end
          S_ARMED, S_GAP: if (trigger) begin
            armed <= 1'b0;
            if (r_delayCfg == '0) r_state <= S_CAPTURE;
            else begin
              r_delay <= r_delayCfg;
              r_state <= S_DELAY;
            end
          end
          S_DELAY: begin
            if (trigger && r_retrig) overrun <= 1'b1;
            if (r_delay == DELAY_WIDTH'(1)) r_state <= S_CAPTURE;
            else r_delay <= r_delay - 1'b1;
          end
          S_CAPTURE: begin
            if (trigger && r_retrig) overrun <= 1'b1;
            r_cVld <= {r_cVld[1:0], 1'b1};
            if (r_addr == r_len) begin
              r_addr    <= '0;
              passCount <= passCount + 1'b1;
              if (passCount == r_passes) begin
                r_state <= S_FLUSH;
                r_flush <= '0;
              end else if (r_retrig) begin
                r_state <= S_GAP;
                armed   <= 1'b1;
              end
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end
          S_FLUSH: if (r_flush == 2'd3) begin
            r_state <= S_IDLE;  busy <= 1'b0;  done <= 1'b1;
          end else begin
            r_flush <= r_flush + 1'b1;
          end
          default: begin
            r_state <= S_IDLE;  armed <= 1'b0;  busy <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge adcClk) begin
    if (w_we) r_mem[r_cAddr[2]] <= w_new;
  end

  always_ff @(posedge adcClk) begin
    if (!adcResetN) r_q <= '0;
    else            r_q <= r_mem[w_ramRdAddr];
  end

  always_ff @(posedge adcClk) begin
    if (!adcResetN) begin
      r_rdVld <= '0;  r_rdA <= '0;  r_rdLane <= '0;  r_rdAcc <= '0;
      rdValid <= 1'b0;  rdData <= '0;
    end else begin
      r_rdVld  <= {r_rdVld[1:0], rdStrobe && (r_state == S_IDLE)};
      if (rdStrobe && (r_state == S_IDLE)) r_rdA <= rdAddr;
      r_rdLane <= {r_rdLane[0], w_rdLane};
      if (r_rdVld[1]) r_rdAcc <= r_q[r_rdLane[1]];
      rdValid  <= r_rdVld[2];
      if (r_rdVld[2]) rdData <= w_rdExt;
    end
  end
endmodule
